note_input_ctrl: RTL and testbench
==================================

NOTE_INPUT_CTRL -- requirements
Module: note_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a synchronized input is accepted.
REQ-002 Parameter HOLDOFF_CYCLES, default 1024: minimum spacing between ld_note pulses, sized to cover the downstream clear-and-redraw of one note glyph.
REQ-003 clk  input  1  sole clock; all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 keys  input  12  raw key switches, asynchronous to clk; key[0]=A, key[1]=A#, key[2]=B, … key[11]=G#.
REQ-006 oct_up  input  1  raw octave-up button, asynchronous.
REQ-007 oct_down  input  1  raw octave-down button, asynchronous.
REQ-008 note  output  4  registered note code: 0 = none, 1..12 = key index+1.
REQ-009 octave  output  2  registered octave, 0..3.
REQ-010 ld_note  output  1  single-cycle load strobe to the note-drawing stage.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer.
REQ-012 Debounce: the accepted value of a synchronized input SHALL update only after that input has differed from its accepted value for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted value restarts the count.
REQ-013 Encoding: the lowest-index accepted key SHALL win (note = index+1); no key accepted gives candidate note 0.
REQ-014 The octave counter SHALL increment on a rising edge of accepted oct_up and decrement on a rising edge of accepted oct_down, saturating at 3 and 0.
REQ-015 Simultaneous rising edges of oct_up and oct_down in the same cycle SHALL leave the octave unchanged.
REQ-016 FSM states are IDLE, LOAD and HOLD.
REQ-017 In IDLE, if the candidate {note,octave} differs from the last-issued value, the FSM SHALL go to LOAD on the next cycle; otherwise it stays in IDLE.
REQ-018 In LOAD (exactly 1 cycle), ld_note=1, and note/octave outputs and the last-issued value SHALL take the candidate value in that same cycle; the next state is HOLD.
REQ-019 In HOLD, the FSM SHALL count HOLDOFF_CYCLES cycles with ld_note=0, then return to IDLE.
REQ-020 Candidate changes during HOLD SHALL NOT be lost: they are re-evaluated in IDLE after HOLD, and intermediate values are dropped, so only the latest is issued.
REQ-021 note and octave SHALL change only in LOAD cycles and hold steady otherwise.
REQ-022 A key release leading to candidate note 0 SHALL be issued like any other change, so the drawn glyph is blanked.
REQ-023 Latency: from a raw edge held stable while in IDLE to ld_note high SHALL be DEBOUNCE_CYCLES+4 cycles (±1 for synchronizer phase).

Reset
REQ-024 While reset is high: note=0, octave=0, ld_note=0, FSM=IDLE, last-issued={0,0}, all synchronizer, debounce and accepted values 0, and the holdoff counter 0; this takes effect immediately, without waiting for a clock edge.
REQ-025 Reset asserted during LOAD or HOLD SHALL abort the operation; after release, no ld_note SHALL occur unless a key or button is actually accepted.

Structure
REQ-026 A shared package SHALL hold the note codes (NOTE_NONE=0, NOTE_A=1 … NOTE_GS=12), the octave width/maximum, and the FSM state encoding; the drawing stage uses the same note codes.
REQ-027 One sub-module, debounce_sync (parameterized width and DEBOUNCE_CYCLES, 2-flop synchronizer plus debounce), SHALL be instantiated for the 12-bit keys and for the 2 octave buttons.

Verification (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=16)
REQ-028 Reset, all inputs 0 for 100 cycles -> ld_note never high; note=0, octave=0.
REQ-029 keys=12'h008 held -> exactly one ld_note pulse, 7-9 cycles after the edge, with note=4 (C) and octave=0; no further pulse while held.
REQ-030 keys[0] high for 3 cycles then low -> no ld_note and note stays 0; key[1] and key[10] held together -> note=2.
REQ-031 Five separate oct_up presses (each held 8 cycles, spaced beyond holdoff) -> octave 1,2,3 with one pulse each; presses 4-5 give no pulse and octave stays 3; oct_up and oct_down pressed simultaneously -> no change.
REQ-032 keys changed 12'h008 -> 12'h010 -> 12'h020 inside one HOLD -> exactly one further pulse, with note=6, in the first cycle after IDLE is re-entered.
REQ-033 reset asserted in HOLD cycle 5 -> note=0, octave=0, ld_note=0 immediately; after release with keys=0 -> no pulse.

Source files
------------

// File: rtl/note_input_ctrl_pkg.sv
// Shared note codes, octave sizing and FSM encoding for the note input path
// and the downstream note-drawing stage.
package note_input_ctrl_pkg;

  localparam int unsigned NUM_KEYS = 12;
  localparam int unsigned OCT_W    = 2;

  typedef logic [3:0]       note_t;
  typedef logic [OCT_W-1:0] octave_t;

  localparam note_t NOTE_NONE = 4'd0;
  localparam note_t NOTE_A    = 4'd1;
  localparam note_t NOTE_AS   = 4'd2;
  localparam note_t NOTE_B    = 4'd3;
  localparam note_t NOTE_C    = 4'd4;
  localparam note_t NOTE_CS   = 4'd5;
  localparam note_t NOTE_D    = 4'd6;
  localparam note_t NOTE_DS   = 4'd7;
  localparam note_t NOTE_E    = 4'd8;
  localparam note_t NOTE_F    = 4'd9;
  localparam note_t NOTE_FS   = 4'd10;
  localparam note_t NOTE_G    = 4'd11;
  localparam note_t NOTE_GS   = 4'd12;

  localparam octave_t OCT_MAX = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Lowest-index pressed key wins; scanning downwards lets it overwrite last.
  function automatic note_t encode_keys(input logic [NUM_KEYS-1:0] k);
    note_t n;
    n = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) n = note_t'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/note_input_ctrl_if.sv
// Key/button inputs and note/octave/load outputs of the note input controller.
interface note_input_ctrl_if;
  import note_input_ctrl_pkg::*;

  logic [NUM_KEYS-1:0] keys;
  logic                oct_up;
  logic                oct_down;
  note_t               note;
  octave_t             octave;
  logic                ld_note;

  modport master (
    output keys, oct_up, oct_down,
    input  note, octave, ld_note
  );

  modport slave (
    input  keys, oct_up, oct_down,
    output note, octave, ld_note
  );

endinterface

// File: rtl/debounce_sync.sv
// Per-bit 2-flop synchronizer followed by a consecutive-cycle debounce filter.
module debounce_sync #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] accepted
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, acc_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        // Any cycle agreeing with the accepted value restarts the count.
        if (sync2_q[i] != acc_q[i]) begin
          if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            acc_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign accepted = acc_q;

endmodule

// File: rtl/note_input_ctrl.sv
// Debounced key/octave input encoder issuing rate-limited note load strobes
// to the note-drawing stage.
module note_input_ctrl
  import note_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 1024
) (
  input logic              clk,
  input logic              reset,
  note_input_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  logic [NUM_KEYS-1:0] keys_acc;
  logic [1:0]          btn_acc, btn_prev_q;
  logic                up_rise, down_rise;
  octave_t             oct_q, oct_d;
  note_t               cand_note;
  logic [1:0]          state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  note_t               note_q;
  octave_t             octave_q;
  logic                ld_q, load;

  debounce_sync #(
    .WIDTH          (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_keys (
    .clk     (clk),
    .reset   (reset),
    .raw     (bus.keys),
    .accepted(keys_acc)
  );

  debounce_sync #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btns (
    .clk     (clk),
    .reset   (reset),
    .raw     ({bus.oct_down, bus.oct_up}),
    .accepted(btn_acc)
  );

  assign up_rise   = btn_acc[0] & ~btn_prev_q[0];
  assign down_rise = btn_acc[1] & ~btn_prev_q[1];
  assign cand_note = encode_keys(keys_acc);

  always_comb begin
    oct_d = oct_q;
    if (up_rise && !down_rise && oct_q != OCT_MAX) begin
      oct_d = oct_q + 1'b1;
    end else if (down_rise && !up_rise && oct_q != '0) begin
      oct_d = oct_q - 1'b1;
    end
  end

  // Candidate is compared only in IDLE, so changes during HOLD collapse to the latest.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: if ({cand_note, oct_q} != {note_q, octave_q}) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load = (state_q == ST_IDLE) && (state_d == ST_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev_q <= '0;
      oct_q      <= '0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      note_q     <= NOTE_NONE;
      octave_q   <= '0;
      ld_q       <= 1'b0;
    end else begin
      btn_prev_q <= btn_acc;
      oct_q      <= oct_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ld_q       <= load;
      // Outputs are loaded on entry to LOAD so they are valid alongside ld_note.
      if (load) begin
        note_q   <= cand_note;
        octave_q <= oct_q;
      end
    end
  end

  assign bus.note    = note_q;
  assign bus.octave  = octave_q;
  assign bus.ld_note = ld_q;

endmodule

// File: tb/tb_note_input_ctrl.sv
// Directed self-checking bench for note_input_ctrl (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=16).
module tb_note_input_ctrl;
  import note_input_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   pulses = 0;
  int   pulse_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   p0, lat, t0;

  always #5 clk = ~clk;

  note_input_ctrl_if bus ();

  note_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ld_note === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int max, output int l);
    l = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.ld_note === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.keys     = '0;
    bus.oct_up   = 1'b0;
    bus.oct_down = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_note", 32'(bus.note), 0);
    check("reset_octave", 32'(bus.octave), 0);
    check("reset_ld", 32'(bus.ld_note), 0);
    cycles(3);
    reset = 1'b0;

    // Idle with all inputs low
    p0 = pulses;
    cycles(100);
    check("idle_pulses", 32'(pulses - p0), 0);
    check("idle_note", 32'(bus.note), 0);
    check("idle_octave", 32'(bus.octave), 0);

    // Single key C
    p0 = pulses;
    bus.keys = 12'h008;
    wait_pulse(20, lat);
    check("c_latency_in_7_9", 32'((lat >= 7 && lat <= 9) ? 1 : 0), 1);
    check("c_note", 32'(bus.note), 4);
    check("c_octave", 32'(bus.octave), 0);
    cycles(40);
    check("c_single_pulse", 32'(pulses - p0), 1);
    check("c_note_held", 32'(bus.note), 4);

    // Release blanks the glyph
    p0 = pulses;
    bus.keys = 12'h000;
    cycles(40);
    check("release_pulse", 32'(pulses - p0), 1);
    check("release_note", 32'(bus.note), 0);

    // Short glitch is rejected
    p0 = pulses;
    bus.keys = 12'h001;
    cycles(3);
    bus.keys = 12'h000;
    cycles(40);
    check("glitch_pulses", 32'(pulses - p0), 0);
    check("glitch_note", 32'(bus.note), 0);

    // Two keys: lowest index wins
    p0 = pulses;
    bus.keys = 12'h402;
    cycles(40);
    check("two_keys_note", 32'(bus.note), 2);
    check("two_keys_pulse", 32'(pulses - p0), 1);
    bus.keys = 12'h000;
    cycles(40);

    // Five octave-up presses saturate at 3
    for (int i = 1; i <= 5; i++) begin
      p0 = pulses;
      bus.oct_up = 1'b1;
      cycles(8);
      bus.oct_up = 1'b0;
      cycles(40);
      check($sformatf("oct_up%0d_octave", i), 32'(bus.octave), 32'((i < 3) ? i : 3));
      check($sformatf("oct_up%0d_pulses", i), 32'(pulses - p0), 32'((i <= 3) ? 1 : 0));
    end

    // Simultaneous up and down cancel
    p0 = pulses;
    bus.oct_up   = 1'b1;
    bus.oct_down = 1'b1;
    cycles(8);
    bus.oct_up   = 1'b0;
    bus.oct_down = 1'b0;
    cycles(40);
    check("both_octave", 32'(bus.octave), 3);
    check("both_pulses", 32'(pulses - p0), 0);

    // Octave down
    p0 = pulses;
    bus.oct_down = 1'b1;
    cycles(8);
    bus.oct_down = 1'b0;
    cycles(40);
    check("down_octave", 32'(bus.octave), 2);
    check("down_pulses", 32'(pulses - p0), 1);

    // Changes inside one HOLD collapse to the latest
    p0 = pulses;
    bus.keys = 12'h008;
    wait_pulse(20, lat);
    check("hold_first_pulse_seen", 32'((lat > 0) ? 1 : 0), 1);
    t0 = cyc;
    bus.keys = 12'h010;
    cycles(7);
    check("note_steady_in_hold", 32'(bus.note), 4);
    bus.keys = 12'h020;
    cycles(40);
    check("hold_total_pulses", 32'(pulses - p0), 2);
    check("hold_final_note", 32'(bus.note), 6);
    check("hold_final_octave", 32'(bus.octave), 2);
    check("hold_reissue_cycle", 32'(pulse_cyc - t0), 18);

    // Reset in HOLD cycle 5 aborts immediately
    bus.keys = 12'h040;
    wait_pulse(20, lat);
    check("pre_reset_note", 32'(bus.note), 7);
    cycles(5);
    reset    = 1'b1;
    bus.keys = 12'h000;
    #1;
    check("abort_note", 32'(bus.note), 0);
    check("abort_octave", 32'(bus.octave), 0);
    check("abort_ld", 32'(bus.ld_note), 0);
    cycles(3);
    reset = 1'b0;
    p0 = pulses;
    cycles(60);
    check("post_reset_pulses", 32'(pulses - p0), 0);
    check("post_reset_note", 32'(bus.note), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
